// File: rtl/multi_group_phase_reconstructor_pkg.sv
// Shared types and constants for the multi-group phase reconstructor:
// error-pulse bit positions and the two-state output FSM encoding.
package phase_reconstructor_pkg;

    localparam int ERR_DUPLICATE = 0;
    localparam int ERR_MISSING   = 1;
    localparam int ERR_GROUP     = 2;
    localparam int ERR_W         = 3;

    typedef enum logic {
        PASS = 1'b0,
        EMIT = 1'b1
    } state_e;

endpackage

// File: rtl/multi_group_phase_reconstructor_if.sv
// AXI-stream style sample bus: data, destination, last marker and handshake.
interface multi_group_phase_reconstructor_if #(
    parameter int DATA_W = 16,
    parameter int DEST_W = 8
);
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [DATA_W-1:0] tdata;
    logic [DEST_W-1:0] tdest;

    modport master (output tvalid, tdata, tdest, tlast, input tready);
    modport slave  (input tvalid, tdata, tdest, tlast, output tready);
endinterface

// File: rtl/multi_group_phase_reconstructor_acc.sv
// Per-group accumulator, received mask and latched missing index, plus the
// negated-sum reconstruction. PHASE_RECONSTRUCTOR_SATURATION_EN clamps instead of wrapping.
module phase_group_accumulator #(
    parameter  int N_PHASES        = 6,
    parameter  int DATA_PATH_WIDTH = 16,
    localparam int PW              = $clog2(N_PHASES),
    localparam int ACC_W           = DATA_PATH_WIDTH + PW
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [PW-1:0]              i_missing_phase,
    input  logic                       i_sel,
    input  logic                       i_clear,
    input  logic [PW-1:0]              i_phase,
    input  logic [DATA_PATH_WIDTH-1:0] i_sample,
    output logic                       o_hit_missing,
    output logic                       o_duplicate,
    output logic                       o_complete,
    output logic [PW-1:0]              o_missing,
    output logic [DATA_PATH_WIDTH-1:0] o_recon
);

    logic signed [ACC_W-1:0] r_acc;
    logic [N_PHASES-1:0]     r_mask;
    logic [PW-1:0]           r_missing;

    logic [PW-1:0]           w_miss_eff;
    logic [N_PHASES-1:0]     w_onehot;
    logic [N_PHASES-1:0]     w_need;
    logic [N_PHASES-1:0]     w_mask_nx;
    logic signed [ACC_W-1:0] w_ext;

    // An empty mask means no frame is open, so the port value is live.
    assign w_miss_eff    = (r_mask == '0) ? i_missing_phase : r_missing;
    assign w_onehot      = N_PHASES'(1) << i_phase;
    assign w_need        = ~(N_PHASES'(1) << w_miss_eff);
    assign o_hit_missing = (i_phase == w_miss_eff);
    assign o_duplicate   = |(r_mask & w_onehot);
    assign w_mask_nx     = o_duplicate ? w_onehot : (r_mask | w_onehot);
    assign o_complete    = !o_hit_missing && (w_mask_nx == w_need);
    assign o_missing     = r_missing;
    assign w_ext         = {{PW{i_sample[DATA_PATH_WIDTH-1]}}, i_sample};

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_acc     <= '0;
            r_mask    <= '0;
            r_missing <= i_missing_phase;
        end else if (i_clear) begin
            r_acc     <= '0;
            r_mask    <= '0;
            r_missing <= i_missing_phase;
        end else begin
            if (r_mask == '0)
                r_missing <= i_missing_phase;
            if (i_sel && !o_hit_missing) begin
                r_acc  <= o_duplicate ? w_ext : r_acc + w_ext;
                r_mask <= w_mask_nx;
            end
        end
    end

`ifdef PHASE_RECONSTRUCTOR_SATURATION_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (DATA_PATH_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    logic signed [ACC_W-1:0] w_neg;
    assign w_neg = -r_acc;

    always_comb begin
        o_recon = w_neg[DATA_PATH_WIDTH-1:0];
        if (w_neg > SAT_HI)
            o_recon = SAT_HI[DATA_PATH_WIDTH-1:0];
        else if (w_neg < SAT_LO)
            o_recon = SAT_LO[DATA_PATH_WIDTH-1:0];
    end
`else
    assign o_recon = DATA_PATH_WIDTH'(-r_acc);
`endif

endmodule

// File: rtl/multi_group_phase_reconstructor.sv
// Forwards phase samples from N_GROUPS polyphase groups and, per completed
// group frame, appends the missing phase as the negated sum (tlast=1).
module multi_group_phase_reconstructor
    import phase_reconstructor_pkg::*;
#(
    parameter  int N_PHASES        = 6,
    parameter  int N_GROUPS        = 2,
    parameter  int DATA_PATH_WIDTH = 16,
    parameter  int DEST_WIDTH      = 8,
    localparam int PW              = $clog2(N_PHASES),
    localparam int GW              = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [PW-1:0]                      i_missing_phase,
    multi_group_phase_reconstructor_if.slave   i_phases_in,
    multi_group_phase_reconstructor_if.master  o_phases_out,
    output logic [ERR_W-1:0]                   o_error_pulse
);

    state_e r_state, w_state_nx;

    logic                       r_out_valid;
    logic                       r_out_last;
    logic [DATA_PATH_WIDTH-1:0] r_out_data;
    logic [DEST_WIDTH-1:0]      r_out_dest;
    logic [GW-1:0]              r_emit_grp;
    logic [ERR_W-1:0]           r_err;

    logic                       w_in_ready;
    logic                       w_accept;
    logic                       w_grp_ok;
    logic [GW-1:0]              w_grp;
    logic [PW-1:0]              w_phase;
    logic                       w_cur_hit, w_cur_dup, w_cur_cmpl;
    logic                       w_fwd, w_go_emit, w_emit_done;
    logic [DATA_PATH_WIDTH-1:0] w_emit_recon;
    logic [DEST_WIDTH-1:0]      w_emit_dest;
    logic                       w_unused_tlast;

    logic [N_GROUPS-1:0]                      w_addr, w_sel, w_clr, w_hit, w_dup, w_cmpl;
    logic [N_GROUPS-1:0][PW-1:0]              w_miss;
    logic [N_GROUPS-1:0][DATA_PATH_WIDTH-1:0] w_recon;

    assign w_unused_tlast = i_phases_in.tlast;

    assign w_grp_ok = (i_phases_in.tdest / DEST_WIDTH'(N_PHASES)) < DEST_WIDTH'(N_GROUPS);
    assign w_grp    = GW'(i_phases_in.tdest / DEST_WIDTH'(N_PHASES));
    assign w_phase  = PW'(i_phases_in.tdest % DEST_WIDTH'(N_PHASES));
    assign w_accept = i_phases_in.tvalid && w_in_ready;

    assign w_cur_hit  = |(w_hit & w_addr);
    assign w_cur_dup  = |(w_dup & w_addr);
    assign w_cur_cmpl = |(w_cmpl & w_addr);

    assign w_fwd       = w_accept && w_grp_ok && !w_cur_hit;
    assign w_go_emit   = w_fwd && w_cur_cmpl;
    assign w_emit_done = (r_state == EMIT) && r_out_valid && r_out_last && o_phases_out.tready;

    assign w_emit_recon = w_recon[r_emit_grp];
    assign w_emit_dest  = DEST_WIDTH'(int'(r_emit_grp) * N_PHASES + int'(w_miss[r_emit_grp]));

    for (genvar g = 0; g < N_GROUPS; g++) begin : g_grp
        assign w_addr[g] = w_grp_ok && (w_grp == GW'(g));
        assign w_sel[g]  = w_accept && w_addr[g];
        assign w_clr[g]  = w_emit_done && (r_emit_grp == GW'(g));

        phase_group_accumulator #(
            .N_PHASES        (N_PHASES),
            .DATA_PATH_WIDTH (DATA_PATH_WIDTH)
        ) u_acc (
            .clock           (clock),
            .reset           (reset),
            .i_missing_phase (i_missing_phase),
            .i_sel           (w_sel[g]),
            .i_clear         (w_clr[g]),
            .i_phase         (w_phase),
            .i_sample        (i_phases_in.tdata),
            .o_hit_missing   (w_hit[g]),
            .o_duplicate     (w_dup[g]),
            .o_complete      (w_cmpl[g]),
            .o_missing       (w_miss[g]),
            .o_recon         (w_recon[g])
        );
    end

    always_ff @(posedge clock) begin
        if (!reset)
            r_state <= PASS;
        else
            r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_in_ready = 1'b0;
        case (r_state)
            PASS: begin
                w_in_ready = reset && (!r_out_valid || o_phases_out.tready);
                if (w_go_emit)
                    w_state_nx = EMIT;
            end
            EMIT: begin
                if (w_emit_done)
                    w_state_nx = PASS;
            end
            default: w_state_nx = PASS;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset)
            r_emit_grp <= '0;
        else if (w_go_emit)
            r_emit_grp <= w_grp;
    end

    // In EMIT, tlast doubles as "reconstructed beat already loaded".
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_out_dest  <= '0;
        end else if (r_state == PASS) begin
            if (w_fwd) begin
                r_out_valid <= 1'b1;
                r_out_last  <= 1'b0;
                r_out_data  <= i_phases_in.tdata;
                r_out_dest  <= i_phases_in.tdest;
            end else if (o_phases_out.tready) begin
                r_out_valid <= 1'b0;
            end
        end else if (r_out_last) begin
            if (o_phases_out.tready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end else if (!r_out_valid || o_phases_out.tready) begin
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b1;
            r_out_data  <= w_emit_recon;
            r_out_dest  <= w_emit_dest;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_err <= '0;
        end else begin
            r_err[ERR_GROUP]     <= w_accept && !w_grp_ok;
            r_err[ERR_MISSING]   <= w_accept && w_grp_ok && w_cur_hit;
            r_err[ERR_DUPLICATE] <= w_fwd && w_cur_dup;
        end
    end

    assign i_phases_in.tready  = w_in_ready;
    assign o_phases_out.tvalid = r_out_valid;
    assign o_phases_out.tlast  = r_out_last;
    assign o_phases_out.tdata  = r_out_data;
    assign o_phases_out.tdest  = r_out_dest;
    assign o_error_pulse       = r_err;

endmodule
